// File: rtl/btn_conditioner.sv
// Button/switch conditioner: four 2-flop synchronizers, each feeding a
// 4-state debounce FSM. Buttons produce one-cycle press pulses; pause toggles.
//
// Ports:
//   clk, reset        - single clock, async active-high reset
//   btn_reset/pause   - raw bouncy push buttons
//   sw_adj/sw_sel     - raw slider switches
//   reset_pulse       - one-cycle pulse per accepted reset press
//   pause_pulse       - one-cycle pulse per accepted pause press
//   pause_state       - 1 = paused, toggled by pause, cleared by reset
//   adj_level         - debounced sw_adj
//   sel_level         - debounced sw_sel (0 = minutes, 1 = seconds)

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level
);

  typedef enum logic [1:0] {
    S_LO = 2'd0,
    W_HI = 2'd1,
    S_HI = 2'd2,
    W_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_MAX = '1;

  logic [1:0]       r_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;

  assign w_s = r_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

  // The count includes the sample that left the stable state, so the
  // switch happens on the edge that sees the D-th differing sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_LO;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_LO: begin
          if (w_s) begin
            r_state <= W_HI;
            r_cnt   <= LP_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        W_HI: begin
          if (!w_s) begin
            r_state <= S_LO;
            r_cnt   <= '0;
          end else if (r_cnt >= LP_LAST) begin
            r_state <= S_HI;
            r_cnt   <= '0;
          end else if (r_cnt != LP_MAX) begin
            r_cnt   <= r_cnt + LP_ONE;
          end
        end
        S_HI: begin
          if (!w_s) begin
            r_state <= W_LO;
            r_cnt   <= LP_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        W_LO: begin
          if (w_s) begin
            r_state <= S_HI;
            r_cnt   <= '0;
          end else if (r_cnt >= LP_LAST) begin
            r_state <= S_LO;
            r_cnt   <= '0;
          end else if (r_cnt != LP_MAX) begin
            r_cnt   <= r_cnt + LP_ONE;
          end
        end
        default: begin
          r_state <= S_LO;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level = (r_state == S_HI) || (r_state == W_LO);

endmodule

module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_reset,
  input  logic btn_pause,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic reset_pulse,
  output logic pause_state,
  output logic pause_pulse,
  output logic adj_level,
  output logic sel_level
);

  logic w_rst_db;
  logic w_pau_db;
  logic w_adj_db;
  logic w_sel_db;
  logic w_rst_rise;
  logic w_pau_rise;

  logic r_rst_lvl;
  logic r_pau_lvl;
  logic r_reset_pulse;
  logic r_pause_pulse;
  logic r_pause_state;
  logic r_adj;
  logic r_sel;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_rst (
    .clk(clk), .reset(reset),
    .i_raw(btn_reset), .o_level(w_rst_db)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_pau (
    .clk(clk), .reset(reset),
    .i_raw(btn_pause), .o_level(w_pau_db)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_adj (
    .clk(clk), .reset(reset),
    .i_raw(sw_adj), .o_level(w_adj_db)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_sel (
    .clk(clk), .reset(reset),
    .i_raw(sw_sel), .o_level(w_sel_db)
  );

  // r_*_lvl lag the FSM level by one cycle, so a rise is seen in the
  // first cycle of a new press; pulse and toggle share that edge.
  assign w_rst_rise = w_rst_db & ~r_rst_lvl;
  assign w_pau_rise = w_pau_db & ~r_pau_lvl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_lvl     <= 1'b0;
      r_pau_lvl     <= 1'b0;
      r_reset_pulse <= 1'b0;
      r_pause_pulse <= 1'b0;
      r_pause_state <= 1'b0;
      r_adj         <= 1'b0;
      r_sel         <= 1'b0;
    end else begin
      r_rst_lvl     <= w_rst_db;
      r_pau_lvl     <= w_pau_db;
      r_reset_pulse <= w_rst_rise;
      r_pause_pulse <= w_pau_rise;
      r_adj         <= w_adj_db;
      r_sel         <= w_sel_db;
      if (w_rst_rise) begin
        r_pause_state <= 1'b0;
      end else if (w_pau_rise) begin
        r_pause_state <= ~r_pause_state;
      end
    end
  end

  assign reset_pulse = r_reset_pulse;
  assign pause_pulse = r_pause_pulse;
  assign pause_state = r_pause_state;
  assign adj_level   = r_adj;
  assign sel_level   = r_sel;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES = 4.
// Outputs are sampled 1 time unit after each rising edge.

module tb_btn_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic btn_reset;
  logic btn_pause;
  logic sw_adj;
  logic sw_sel;
  logic reset_pulse;
  logic pause_state;
  logic pause_pulse;
  logic adj_level;
  logic sel_level;

  int n_vec = 0;
  int n_err = 0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_reset(btn_reset),
    .btn_pause(btn_pause),
    .sw_adj(sw_adj),
    .sw_sel(sw_sel),
    .reset_pulse(reset_pulse),
    .pause_state(pause_state),
    .pause_pulse(pause_pulse),
    .adj_level(adj_level),
    .sel_level(sel_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx,
                     input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%b expected=%b",
             tag, idx, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset     = 1'b1;
    btn_reset = 1'b0;
    btn_pause = 1'b0;
    sw_adj    = 1'b0;
    sw_sel    = 1'b0;
    #1;
    chk("rst_rp", 0, reset_pulse, 1'b0);
    chk("rst_pp", 0, pause_pulse, 1'b0);
    chk("rst_ps", 0, pause_state, 1'b0);
    chk("rst_adj", 0, adj_level, 1'b0);
    chk("rst_sel", 0, sel_level, 1'b0);
    idle(2);
    reset = 1'b0;
    idle(3);

    // Clean press held 20 cycles: pulse after the 7th edge (index 6).
    btn_pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("p1_pulse", i, pause_pulse, 1'(i == 6));
      chk("p1_state", i, pause_state, 1'(i >= 6));
    end
    btn_pause = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rel_pulse", i, pause_pulse, 1'b0);
      chk("rel_state", i, pause_state, 1'b1);
    end
    btn_pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("p2_pulse", i, pause_pulse, 1'(i == 6));
      chk("p2_state", i, pause_state, 1'(i < 6));
    end
    btn_pause = 1'b0;
    idle(10);

    // Bounce 1,0,1,0 then held high.
    btn_pause = 1'b1; step();
    chk("bnc_pulse", 0, pause_pulse, 1'b0);
    btn_pause = 1'b0; step();
    chk("bnc_pulse", 1, pause_pulse, 1'b0);
    btn_pause = 1'b1; step();
    chk("bnc_pulse", 2, pause_pulse, 1'b0);
    btn_pause = 1'b0; step();
    chk("bnc_pulse", 3, pause_pulse, 1'b0);
    btn_pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bnc_hold", i, pause_pulse, 1'(i == 6));
      chk("bnc_state", i, pause_state, 1'(i >= 6));
    end
    btn_pause = 1'b0;
    idle(10);

    // Reset button clears pause_state in the pulse cycle.
    btn_reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("clr_rp", i, reset_pulse, 1'(i == 6));
      chk("clr_ps", i, pause_state, 1'(i < 6));
    end
    btn_reset = 1'b0;
    idle(10);

    // Both buttons together: clear wins.
    btn_reset = 1'b1;
    btn_pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("both_rp", i, reset_pulse, 1'(i == 6));
      chk("both_pp", i, pause_pulse, 1'(i == 6));
      chk("both_ps", i, pause_state, 1'b0);
    end
    btn_reset = 1'b0;
    btn_pause = 1'b0;
    idle(10);

    // Three-cycle glitch on sw_sel is rejected.
    sw_sel = 1'b1;
    idle(3);
    sw_sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("glitch_sel", i, sel_level, 1'b0);
    end
    sw_sel = 1'b1;
    sw_adj = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk("sel_lvl", i, sel_level, 1'(i >= 6));
      chk("adj_lvl", i, adj_level, 1'(i >= 6));
      chk("sel_rp", i, reset_pulse, 1'b0);
      chk("sel_pp", i, pause_pulse, 1'b0);
      chk("sel_ps", i, pause_state, 1'b0);
    end
    sw_adj = 1'b0;
    idle(10);
    chk("adj_off", 0, adj_level, 1'b0);

    // Reset mid-debounce (counter = 2), released with button held.
    btn_pause = 1'b1;
    idle(4);
    reset = 1'b1;
    #1;
    chk("mid_sel", 0, sel_level, 1'b0);
    chk("mid_pp", 0, pause_pulse, 1'b0);
    chk("mid_ps", 0, pause_state, 1'b0);
    step();
    step();
    chk("mid_hold", 0, pause_pulse, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_pp", i, pause_pulse, 1'(i == 6));
      chk("post_ps", i, pause_state, 1'(i >= 6));
      chk("post_sel", i, sel_level, 1'(i >= 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable synchronized samples required to accept a new level (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 Parameter: CNT_W, default 24, meaning the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 Port: clk, input, 1, the single clock (100 MHz master); all flops are on its rising edge.
REQ-004 Port: reset, input, 1, asynchronous active-high reset.
REQ-005 Port: btn_reset, input, 1, raw reset push button (asynchronous, bouncy).
REQ-006 Port: btn_pause, input, 1, raw pause push button (asynchronous, bouncy).
REQ-007 Port: sw_adj, input, 1, raw ADJ slider switch.
REQ-008 Port: sw_sel, input, 1, raw SEL slider switch (0 = minutes, 1 = seconds).
REQ-009 Port: reset_pulse, output, 1, one-cycle pulse on each accepted btn_reset press.
REQ-010 Port: pause_state, output, 1, run/pause level (1 = paused), toggled by each accepted btn_pause press.
REQ-011 Port: pause_pulse, output, 1, one-cycle pulse on each accepted btn_pause press.
REQ-012 Port: adj_level, output, 1, debounced sw_adj.
REQ-013 Port: sel_level, output, 1, debounced sw_sel.

Function
REQ-014 Each of the four raw inputs SHALL pass through a dedicated 2-flop synchronizer before any other logic.
REQ-015 Each channel SHALL implement a 4-state FSM.
  - STABLE_LO: the counter is held at 0; a synchronized sample of 1 SHALL move the FSM to WAIT_HI with counter = 1.
  - WAIT_HI: a sample of 1 increments the counter; a sample of 0 SHALL return the FSM to STABLE_LO with counter = 0.
  - STABLE_HI and WAIT_LO: mirror images of STABLE_LO and WAIT_HI.
REQ-016 The FSM SHALL move WAIT_HI -> STABLE_HI on the edge where the count of consecutive differing samples reaches DEBOUNCE_CYCLES; WAIT_LO -> STABLE_LO SHALL behave the same way.
REQ-017 The debounced level SHALL be 1 exactly in STABLE_HI and WAIT_LO.
REQ-018 Latency: a clean raw transition SHALL appear on the debounced level 2 + DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no level change and no pulse.
REQ-020 The counter SHALL saturate and never wrap; it SHALL return to 0 on every FSM return to a STABLE state.
REQ-021 reset_pulse SHALL be registered and high for exactly one cycle, in the first cycle the debounced btn_reset level is 1 after having been 0.
REQ-022 pause_pulse SHALL follow the same rule as REQ-021 for the debounced btn_pause level; release SHALL produce no pulse.
REQ-023 pause_state SHALL toggle on the edge at which pause_pulse is asserted.
REQ-024 reset_pulse SHALL clear pause_state to 0 (running) in the same cycle it is asserted.
REQ-025 If reset_pulse and pause_pulse are asserted in the same cycle, the clear SHALL take priority and pause_state SHALL be 0.
REQ-026 Holding a button SHALL produce exactly one pulse; the next pulse SHALL require release, then a fresh press, each debounced.
REQ-027 adj_level and sel_level SHALL equal their channel's debounced level, with no pulse generation.
REQ-028 adj_level and sel_level SHALL NOT affect pause_state.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 While reset is high, all synchronizer flops, FSMs (STABLE_LO), counters and outputs SHALL be 0, immediately and without waiting for a clk edge.
REQ-031 After reset deassertion, a raw input already held at 1 SHALL be treated as a new press: it debounces normally and produces its pulse per REQ-018.
REQ-032 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be emitted for that edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Clean btn_pause press held 20 cycles -> pause_pulse high exactly 1 cycle, 6 cycles after the first sampling edge; pause_state 0->1; release then re-press -> pause_state 1->0.
REQ-034 btn_pause bounced 1,0,1,0 at 1-cycle spacing, then held 1 -> exactly one pause_pulse, 6 cycles after the final rising sample; no earlier pulse.
REQ-035 pause_state=1, then btn_reset pressed -> reset_pulse 1 cycle; pause_state 0 in the same cycle.
REQ-036 btn_reset and btn_pause raw rise on the same edge with pause_state=0 -> both pulses in the same cycle; pause_state stays 0.
REQ-037 sw_sel 3-cycle glitch -> sel_level stays 0; sw_sel held 1 -> sel_level 1 at cycle 6, stays 1 indefinitely; no pulse outputs.
REQ-038 reset asserted at counter = 2 with btn_pause high, released while still high -> outputs 0 immediately; pause_pulse 6 cycles after the first post-reset sampling edge.
